ex_mem_stage: RTL and testbench

Parametrised EX/MEM pipeline stage register with a valid/ready handshake, a 2-entry skid buffer, flush and stall support, and qualified forwarding outputs. It sits between the EX stage (ALU, store-data mux) and the MEM stage (data memory, forwarding unit). It replaces the bare always-latching EX/MEM register, so back-pressure from a multi-cycle data memory and branch/exception flushes are handled without corrupting in-flight instructions.

---
 rtl/ex_mem_stage.sv | 109 ++++++++++
 tb/tb_ex_mem_stage.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with valid/ready handshake, optional 2-entry skid
// buffer, flush, and valid-qualified control/forwarding outputs.
module ex_mem_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int WB_W   = 2,
  parameter int M_W    = 2,
  parameter int SKID   = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              flush_i,
  input  logic [WB_W-1:0]   WB_i,
  input  logic [M_W-1:0]    M_i,
  input  logic [ADDR_W-1:0] RDaddr_i,
  input  logic [DATA_W-1:0] ALUdata_i,
  input  logic [DATA_W-1:0] mux7_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [WB_W-1:0]   WB_o,
  output logic              FW_o,
  output logic              MemRead_o,
  output logic              MemWrite_o,
  output logic [ADDR_W-1:0] RDaddr_o,
  output logic [DATA_W-1:0] ALUdata_o,
  output logic [DATA_W-1:0] data_o
);

  localparam int PW = WB_W + M_W + ADDR_W + 2*DATA_W;

  logic [PW-1:0] in_pl, main_q, main_d, skid_q, skid_d;
  logic          main_v_q, main_v_d, skid_v_q, skid_v_d;
  logic          ready, accept, retire;
  logic [WB_W-1:0] wb_h;
  logic [M_W-1:0]  m_h;

  assign in_pl  = {WB_i, M_i, RDaddr_i, ALUdata_i, mux7_i};
  assign retire = main_v_q & ready_i;

  // Skid build keeps ready purely registered so ready_i never reaches ready_o.
  generate
    if (SKID != 0) begin : g_skid
      assign ready = !skid_v_q;
    end else begin : g_noskid
      assign ready = !main_v_q | ready_i;
    end
  endgenerate

  assign ready_o = ready & !rst_i;
  assign accept  = valid_i & ready_o;

  always_comb begin
    main_d   = main_q;
    main_v_d = main_v_q;
    skid_d   = skid_q;
    skid_v_d = skid_v_q;
    if (flush_i) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (SKID != 0) begin
      if (!main_v_q || retire) begin
        if (skid_v_q) begin
          main_d   = skid_q;
          main_v_d = 1'b1;
          skid_v_d = accept;
          if (accept) skid_d = in_pl;
        end else begin
          main_v_d = accept;
          if (accept) main_d = in_pl;
        end
      end else if (accept) begin
        skid_d   = in_pl;
        skid_v_d = 1'b1;
      end
    end else begin
      if (accept) begin
        main_d   = in_pl;
        main_v_d = 1'b1;
      end else if (retire) begin
        main_v_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
    end else begin
      main_q   <= main_d;
      skid_q   <= skid_d;
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
    end
  end

  assign {wb_h, m_h, RDaddr_o, ALUdata_o, data_o} = main_q;

  assign valid_o    = main_v_q;
  assign WB_o       = wb_h & {WB_W{main_v_q}};
  assign MemRead_o  = main_v_q & m_h[0];
  assign MemWrite_o = main_v_q & m_h[1];
  assign FW_o       = main_v_q & wb_h[0] & (RDaddr_o != '0);

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: skid build (u1) and single-entry build (u0)
// checked against hand-computed values and a small FIFO scoreboard.
module tb_ex_mem_stage;
  logic clk = 0;
  always #5 clk = ~clk;

  logic        rst, vld, rdy, fl, vld0, rdy0, fl0;
  logic [1:0]  wb, m;
  logic [4:0]  rd;
  logic [31:0] alu, st;

  logic        rdy_o1, vo1, fw1, mr1, mw1;
  logic [1:0]  wb1;
  logic [4:0]  rd1;
  logic [31:0] alu1, d1;
  logic        rdy_o0, vo0, fw0, mr0, mw0;
  logic [1:0]  wb0;
  logic [4:0]  rd0;
  logic [31:0] alu0, d0;

  ex_mem_stage #(.SKID(1)) u1 (
    .clk_i(clk), .rst_i(rst), .valid_i(vld), .ready_o(rdy_o1), .flush_i(fl),
    .WB_i(wb), .M_i(m), .RDaddr_i(rd), .ALUdata_i(alu), .mux7_i(st),
    .valid_o(vo1), .ready_i(rdy), .WB_o(wb1), .FW_o(fw1), .MemRead_o(mr1),
    .MemWrite_o(mw1), .RDaddr_o(rd1), .ALUdata_o(alu1), .data_o(d1));

  ex_mem_stage #(.SKID(0)) u0 (
    .clk_i(clk), .rst_i(rst), .valid_i(vld0), .ready_o(rdy_o0), .flush_i(fl0),
    .WB_i(wb), .M_i(m), .RDaddr_i(rd), .ALUdata_i(alu), .mux7_i(st),
    .valid_o(vo0), .ready_i(rdy0), .WB_o(wb0), .FW_o(fw0), .MemRead_o(mr0),
    .MemWrite_o(mw0), .RDaddr_o(rd0), .ALUdata_o(alu0), .data_o(d0));

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drv(input logic v, input logic [1:0] w, input logic [1:0] mm,
                     input logic [4:0] r, input logic [31:0] a, input logic [31:0] s);
    vld = v; wb = w; m = mm; rd = r; alu = a; st = s;
  endtask

  logic [31:0] q[$];
  logic [31:0] exp_d;
  logic        acc, ret;

  initial begin
    rst = 1; vld = 0; rdy = 1; fl = 0; vld0 = 0; rdy0 = 1; fl0 = 0;
    wb = 0; m = 0; rd = 0; alu = 0; st = 0;

    // reset
    step();
    chk("rst_ready", rdy_o1, 0);
    chk("rst_valid", vo1, 0);
    chk("rst_ready0", rdy_o0, 0);
    step();
    chk("rst_alu", alu1, 0);
    chk("rst_wb", wb1, 0);
    chk("rst_data", d1, 0);
    rst = 0; #1;
    chk("post_rst_ready", rdy_o1, 1);
    chk("post_rst_ready0", rdy_o0, 1);
    chk("post_rst_valid", vo1, 0);
    chk("post_rst_rd", rd1, 0);

    // streaming, no bubbles
    rdy = 1;
    drv(1, 2'b01, 2'b00, 5, 32'h10, 0); step();
    chk("s1_alu", alu1, 32'h10); chk("s1_fw", fw1, 1); chk("s1_rdy", rdy_o1, 1);
    drv(1, 2'b01, 2'b00, 5, 32'h20, 0); step();
    chk("s2_alu", alu1, 32'h20); chk("s2_fw", fw1, 1); chk("s2_vld", vo1, 1);
    drv(1, 2'b01, 2'b00, 5, 32'h30, 0); step();
    chk("s3_alu", alu1, 32'h30); chk("s3_fw", fw1, 1); chk("s3_rd", rd1, 5);
    drv(0, 2'b01, 2'b00, 5, 32'h40, 0); step();
    chk("s_end_vld", vo1, 0); chk("s_end_fw", fw1, 0);

    // stall into skid, then drain in order
    rdy = 0;
    drv(1, 2'b01, 2'b00, 6, 32'hA, 0); step();
    chk("st_a_alu", alu1, 32'hA); chk("st_a_rdy", rdy_o1, 1);
    drv(1, 2'b01, 2'b00, 6, 32'hB, 0); step();
    chk("st_b_alu", alu1, 32'hA); chk("st_b_rdy", rdy_o1, 0);
    drv(1, 2'b01, 2'b00, 6, 32'hC, 0); step();
    chk("st_full_alu", alu1, 32'hA); chk("st_full_rdy", rdy_o1, 0); chk("st_full_rd", rd1, 6);
    vld = 0; rdy = 1; step();
    chk("st_drain1_alu", alu1, 32'hB); chk("st_drain1_vld", vo1, 1); chk("st_drain1_rdy", rdy_o1, 1);
    step();
    chk("st_drain2_vld", vo1, 0);

    // flush while full (input offered but not accepted)
    rdy = 0;
    drv(1, 2'b01, 2'b10, 3, 32'h1, 0); step();
    drv(1, 2'b01, 2'b10, 3, 32'h2, 0); step();
    chk("fl_full_rdy", rdy_o1, 0); chk("fl_full_mw", mw1, 1);
    drv(1, 2'b01, 2'b10, 3, 32'h3, 0); fl = 1; step();
    fl = 0;
    chk("fl_vld", vo1, 0); chk("fl_mw", mw1, 0); chk("fl_fw", fw1, 0); chk("fl_rdy", rdy_o1, 1);
    // flush with an accept in the same cycle
    drv(1, 2'b01, 2'b10, 3, 32'h4, 0); step();
    chk("fl2_pre_alu", alu1, 32'h4);
    drv(1, 2'b01, 2'b10, 3, 32'h5, 0); fl = 1; step();
    fl = 0; vld = 0;
    chk("fl2_vld", vo1, 0); chk("fl2_rdy", rdy_o1, 1);
    step();
    chk("fl2_dropped_vld", vo1, 0);

    // store, load, x0 forwarding
    rdy = 1;
    drv(1, 2'b00, 2'b10, 7, 32'h100, 32'hDEAD); step();
    chk("store_mw", mw1, 1); chk("store_mr", mr1, 0); chk("store_data", d1, 32'hDEAD);
    drv(1, 2'b01, 2'b01, 7, 32'h104, 0); step();
    chk("load_mr", mr1, 1); chk("load_mw", mw1, 0); chk("load_fw", fw1, 1);
    drv(1, 2'b01, 2'b00, 0, 32'h108, 0); step();
    chk("x0_fw", fw1, 0); chk("x0_wb", wb1, 2'b01); chk("x0_vld", vo1, 1);
    drv(1, 2'b01, 2'b00, 1, 32'h10C, 0); step();
    chk("x1_fw", fw1, 1);
    drv(0, 2'b01, 2'b01, 1, 32'h110, 0); step();
    chk("idle_wb", wb1, 0); chk("idle_fw", fw1, 0); chk("idle_mr", mr1, 0);

    // single-entry build against a FIFO scoreboard
    for (int i = 0; i < 300; i++) begin
      vld0 = (i % 3) != 1;
      rdy0 = ((i * 7) % 5) < 3;
      alu  = 32'h1000 + i;
      #1;
      chk("se_ready", rdy_o0, (!vo0 | rdy0));
      chk("se_valid", vo0, q.size() != 0);
      acc = vld0 & rdy_o0;
      ret = vo0 & rdy0;
      if (ret) begin
        exp_d = (q.size() != 0) ? q.pop_front() : 32'hBAD0BAD0;
        chk("se_data", alu0, exp_d);
      end
      if (acc) q.push_back(alu);
      step();
    end
    vld0 = 0; rdy0 = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (vo0) begin
        exp_d = (q.size() != 0) ? q.pop_front() : 32'hBAD0BAD0;
        chk("se_drain", alu0, exp_d);
      end
      step();
    end
    chk("se_empty", q.size(), 0);
    chk("se_final_vld", vo0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
